// File: rtl/softmax_seq_ctrl.sv
// Sequential softmax: one shared exponent unit and one shared divider, scheduled
// over 10 EXP cycles and 10 DIV cycles, with a running argmax over the results.

module hw_exp #(
  parameter int BUS_WIDTH             = 32,
  parameter int NUM_DECIMAL_IN_BINARY = 6
) (
  input  logic signed [BUS_WIDTH-1:0] x,
  output logic signed [25:0]          y
);
  localparam int F  = NUM_DECIMAL_IN_BINARY;
  localparam int PW = BUS_WIDTH + 8;
  // e^x = 2^(x*log2e): log2e ~ 1477/1024 rounded into QF, 2^frac ~ 1+frac
  localparam int LOG2E_Q = (1477 * (1 << F) + 512) / 1024;
  localparam int NMAX    = 24 - F;

  localparam logic signed [PW-1:0] K      = PW'(LOG2E_Q);
  localparam logic signed [PW-1:0] NMAX_W = PW'(NMAX);
  localparam logic signed [PW-1:0] NMIN_W = -PW'(F);

  logic signed [PW-1:0] x_ext, t, n;
  logic [F:0]           mant;
  logic [4:0]           rsh;

  always_comb begin
    x_ext = PW'(x);
    t     = (x_ext * K) >>> F;
    n     = t >>> F;
    mant  = {1'b1, t[F-1:0]};
    rsh   = -n[4:0];
    if (n > NMAX_W)       y = 26'h1FF_FFFF;
    else if (!n[PW-1])    y = {{(25-F){1'b0}}, mant} << n[4:0];
    else if (n >= NMIN_W) y = {{(25-F){1'b0}}, mant} >> rsh;
    else                  y = '0;
  end
endmodule

module fixed_point_div #(
  parameter int NUM_DECIMAL_IN_BINARY = 6
) (
  input  logic signed [25:0] a,
  input  logic signed [25:0] b,
  output logic signed [9:0]  q
);
  localparam int F  = NUM_DECIMAL_IN_BINARY;
  localparam int DW = 27 + F;

  logic signed [DW-1:0] num, dv;

  // b==0 is masked by the caller; the substitute divisor only avoids a divide-by-zero
  always_comb begin
    num = {a[25], a, {F{1'b0}}};
    dv  = (b == '0) ? DW'(1) : {{(F+1){b[25]}}, b};
    q   = 10'(num / dv);
  end
endmodule

module softmax_seq_ctrl #(
  parameter int BUS_WIDTH             = 32,
  parameter int NUM_DECIMAL_IN_BINARY = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [9:0][BUS_WIDTH-1:0]       dense_sum2,
  output logic                            busy,
  output logic                            done,
  output logic [9:0][9:0]                 dense_softmax,
  output logic [3:0]                      pred_class
);
  typedef enum logic [1:0] {IDLE, EXP, DIV} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                idx_q, idx_d;
  logic [9:0][BUS_WIDTH-1:0] x_buf_q, x_buf_d;
  logic [9:0][25:0]          e_buf_q, e_buf_d;
  logic signed [25:0]        den_q, den_d;
  logic signed [9:0]         best_val_q, best_val_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic [9:0][9:0]           softmax_q, softmax_d;
  logic [3:0]                pred_q, pred_d;

  logic signed [BUS_WIDTH-1:0] exp_x;
  logic signed [25:0]          exp_y, div_a;
  logic signed [9:0]           div_q, prob;

  hw_exp #(
    .BUS_WIDTH(BUS_WIDTH),
    .NUM_DECIMAL_IN_BINARY(NUM_DECIMAL_IN_BINARY)
  ) u_exp (
    .x(exp_x),
    .y(exp_y)
  );

  fixed_point_div #(
    .NUM_DECIMAL_IN_BINARY(NUM_DECIMAL_IN_BINARY)
  ) u_div (
    .a(div_a),
    .b(den_q),
    .q(div_q)
  );

  always_comb begin
    exp_x      = x_buf_q[idx_q];
    div_a      = e_buf_q[idx_q];
    prob       = (den_q == '0) ? '0 : div_q;
    state_d    = state_q;
    idx_d      = idx_q;
    x_buf_d    = x_buf_q;
    e_buf_d    = e_buf_q;
    den_d      = den_q;
    best_val_d = best_val_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    softmax_d  = softmax_q;
    pred_d     = pred_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_buf_d    = dense_sum2;
          den_d      = '0;
          idx_d      = '0;
          best_val_d = '0;
          busy_d     = 1'b1;
          state_d    = EXP;
        end
      end
      EXP: begin
        e_buf_d[idx_q] = exp_y;
        den_d          = den_q + exp_y;
        if (idx_q == 4'd9) begin
          idx_d   = '0;
          state_d = DIV;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DIV: begin
        softmax_d[idx_q] = prob;
        // strict compare keeps the lowest index on ties
        if (idx_q == 4'd0 || prob > best_val_q) begin
          best_val_d = prob;
          pred_d     = idx_q;
        end
        if (idx_q == 4'd9) begin
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      x_buf_q    <= '0;
      e_buf_q    <= '0;
      den_q      <= '0;
      best_val_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      softmax_q  <= '0;
      pred_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      x_buf_q    <= x_buf_d;
      e_buf_q    <= e_buf_d;
      den_q      <= den_d;
      best_val_q <= best_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      softmax_q  <= softmax_d;
      pred_q     <= pred_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign dense_softmax = softmax_q;
  assign pred_class    = pred_q;
endmodule

// File: doc/softmax_seq_ctrl.md
# softmax_seq_ctrl

Sequential softmax engine for the output stage of the CNN accelerator. It replaces the ten parallel exponent units and ten parallel dividers with one `hw_exp` instance and one `fixed_point_div` instance, scheduled over 20 cycles by a start/done controller. It latches the ten dense-layer sums and writes ten normalized 10-bit probabilities. It also reports the predicted class (argmax).

## Interface
- `BUS_WIDTH`, 32, width of each signed dense-layer sum.
- `NUM_DECIMAL_IN_BINARY`, 6, fractional bits of the fixed-point format (1.0 = 64).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a run; sampled only in IDLE.
- `dense_sum2[10]`  in  signed BUS_WIDTH each  class scores; sampled on the accepting edge only.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  single-cycle pulse; results are valid from this cycle onward.
- `dense_softmax[10]`  out  signed 10 each  per-class probabilities, registered.
- `pred_class`  out  4  index of the maximum `dense_softmax`, registered.

## Operation
- States: IDLE, EXP, DIV. `idx` is a 4-bit counter with range 0..9.
- Internal registers:
  - `x_buf[10]`: latched inputs.
  - `e_buf[10]`: signed 26-bit exponent results.
  - `den`: signed 26-bit sum.
  - `best_val`: signed 10-bit running maximum.
- IDLE, `start` high on an edge:
  - latch all ten `dense_sum2` into `x_buf`;
  - clear `den`, `idx` and `best_val`;
  - go to EXP and set `busy` high.
- IDLE, `start` low: hold all state.
- EXP, each edge:
  - drive the `hw_exp` input from `x_buf[idx]`;
  - `e_buf[idx]` <= exp result; `den` <= `den` + exp result, wrapping mod 2^26 with no saturation;
  - when `idx`=9, set `idx`=0 and go to DIV; otherwise increment `idx`.
- DIV, each edge:
  - drive `fixed_point_div` with a=`e_buf[idx]`, b=`den`;
  - `dense_softmax[idx]` <= the divider result, i.e. (a << NUM_DECIMAL_IN_BINARY)/b truncated toward zero to 10 bits;
  - if `den`==0, write 0 instead of the divider output.
- Argmax update in DIV:
  - at `idx`=0, unconditionally load `best_val` with the new value and set `pred_class`=0;
  - for `idx`>0, update only when new value > `best_val` (signed compare), so ties keep the lowest index.
- DIV with `idx`=9: go to IDLE, `busy` <= 0, `done` <= 1.
- `done` is cleared on the following edge.
- `start` while `busy` is high is ignored and is not queued.
- `start` in the cycle where `done` is high is accepted, since the state is already IDLE.
- `dense_softmax` and `pred_class` hold their last values between runs. During a run, elements are overwritten in index order in DIV.
- Changes on `dense_sum2` after the accepting edge have no effect on the run.

## Timing
- Reset (`rst_n` low, at any time and in any state) asynchronously forces:
  - state IDLE;
  - `busy`=0, `done`=0, `pred_class`=0;
  - all `dense_softmax`=0;
  - `idx`, `den`, `e_buf`, `x_buf` and `best_val` to 0.
- A reset mid-run aborts the run; no `done` is produced.
- Accepting edge k: `busy` goes high after edge k.
- EXP steps occur on edges k+1..k+10; DIV steps on edges k+11..k+20.
- After edge k+20: `done`=1 and `busy`=0, with all outputs final.
- Start-to-done latency is 20 cycles; back-to-back throughput is one run per 21 cycles.
- Arithmetic is pure combinational within each step; each cycle has a single exp→register path or divider→register path.
- Outputs are glitch-free registers.

## Test plan
- All `dense_sum2`=0, pulse `start`:
  - `done` rises exactly 20 cycles after the accepting edge;
  - every `dense_softmax`=6 (64·64/640 truncated);
  - `pred_class`=0 (tie, lowest index).
- `dense_sum2[3]`=320 (5.0), others 0:
  - each `dense_softmax[i]` matches a bit-exact golden model of `hw_exp` followed by divide;
  - `pred_class`=3;
  - `busy` is high for exactly 20 cycles.
- Hold `start` high continuously with inputs all 0:
  - runs chain every 21 cycles;
  - a `start` high during `busy` does not restart or shorten the run.
- Change `dense_sum2` from all 0 to `dense_sum2[7]`=256 one cycle after the accepting edge:
  - results equal the all-zero case (probabilities 6, `pred_class`=0).
- Assert `rst_n` low at cycle 12 of a run:
  - all outputs read 0 immediately, with no `done`;
  - after release, a new `start` completes normally in 20 cycles.
- Force an exponent sum of 0 (all `dense_sum2` at most negative, with the `hw_exp` result 0):
  - all `dense_softmax`=0 and `pred_class`=0, with `done` asserted normally.
